// File: rtl/borrowskip_sub_pipe.sv
// borrowskip_sub_pipe
//   Three-stage pipelined subtractor, D = A - B - Bin, built from BLOCK-bit
//   borrow-skip blocks. The low half of the difference is formed in S1 and
//   the high half in S2. Valid/ready handshake on both sides.
//
//   Optional feature macro: BORROWSKIP_OVF_EN (adds ovf_out, the signed
//   two's-complement overflow, pipelined alongside D_out).
//
//   Ports:
//     clk        rising-edge clock
//     rst        asynchronous, active-high reset
//     in_valid   operand set present
//     in_ready   block can accept an operand set this cycle
//     A_in       minuend
//     B_in       subtrahend
//     Bin_in     borrow-in
//     out_valid  result present
//     out_ready  consumer accepts the result
//     D_out      difference
//     Bout_out   borrow-out (1 = A < B + Bin, unsigned)
//     ovf_out    signed overflow (only with BORROWSKIP_OVF_EN)

// Skip adder: sum = a + b + cin, rippling inside each block; a block whose
// bits all propagate hands its carry-in straight to its carry-out.
module borrowskip_skip_add #(
  parameter int W     = 8,
  parameter int BLOCK = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);
  localparam int NB = W / BLOCK;

  logic [NB-1:0] prop;

  genvar gi;
  generate
    for (gi = 0; gi < NB; gi++) begin : g_prop
      assign prop[gi] = &(a[gi*BLOCK +: BLOCK] ^ b[gi*BLOCK +: BLOCK]);
    end
  endgenerate

  // Written as one combinational walk so the block-to-block carry chain is
  // a variable rather than a self-referencing vector.
  always_comb begin
    logic bc;
    logic rc;
    sum = '0;
    bc  = cin;
    rc  = 1'b0;
    for (int blk = 0; blk < NB; blk++) begin
      rc = bc;
      for (int j = 0; j < BLOCK; j++) begin
        sum[blk*BLOCK+j] = a[blk*BLOCK+j] ^ b[blk*BLOCK+j] ^ rc;
        rc = (a[blk*BLOCK+j] & b[blk*BLOCK+j]) |
             ((a[blk*BLOCK+j] ^ b[blk*BLOCK+j]) & rc);
      end
      bc = prop[blk] ? bc : rc;
    end
    cout = bc;
  end
endmodule

module borrowskip_sub_pipe #(
  parameter int WIDTH = 16,
  parameter int BLOCK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A_in,
  input  logic [WIDTH-1:0] B_in,
  input  logic             Bin_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] D_out,
`ifdef BORROWSKIP_OVF_EN
  output logic             ovf_out,
`endif
  output logic             Bout_out
);
  localparam int HALF = WIDTH / 2;

  // S0 payload
  logic [WIDTH-1:0] a0_reg, b0_reg;
  logic             bin0_reg, v0_reg;
  // S1 payload
  logic [HALF-1:0]  d_lo1_reg, a_hi1_reg, b_hi1_reg;
  logic             c1_reg, v1_reg;

  logic             adv0, adv1, adv2;
  logic [HALF-1:0]  d_lo_next, d_hi_next;
  logic             c_mid_next, c_top_next;

  // A stage advances when it is empty or the stage after it advances.
  assign adv2     = !out_valid || out_ready;
  assign adv1     = !v1_reg || adv2;
  assign adv0     = !v0_reg || adv1;
  assign in_ready = adv0;

  // Subtraction as A + ~B + ~Bin.
  borrowskip_skip_add #(.W(HALF), .BLOCK(BLOCK)) u_lo (
    .a    (a0_reg[HALF-1:0]),
    .b    (~b0_reg[HALF-1:0]),
    .cin  (~bin0_reg),
    .sum  (d_lo_next),
    .cout (c_mid_next)
  );

  borrowskip_skip_add #(.W(HALF), .BLOCK(BLOCK)) u_hi (
    .a    (a_hi1_reg),
    .b    (~b_hi1_reg),
    .cin  (c1_reg),
    .sum  (d_hi_next),
    .cout (c_top_next)
  );

`ifdef BORROWSKIP_OVF_EN
  logic ovf_next;
  // Carry into the MSB is recovered from the MSB sum bit and its operands.
  assign ovf_next = (a_hi1_reg[HALF-1] ^ ~b_hi1_reg[HALF-1] ^ d_hi_next[HALF-1])
                    ^ c_top_next;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a0_reg    <= '0;
      b0_reg    <= '0;
      bin0_reg  <= 1'b0;
      v0_reg    <= 1'b0;
      d_lo1_reg <= '0;
      a_hi1_reg <= '0;
      b_hi1_reg <= '0;
      c1_reg    <= 1'b0;
      v1_reg    <= 1'b0;
      D_out     <= '0;
      Bout_out  <= 1'b0;
      out_valid <= 1'b0;
`ifdef BORROWSKIP_OVF_EN
      ovf_out   <= 1'b0;
`endif
    end else begin
      if (adv0) begin
        v0_reg <= in_valid;
        if (in_valid) begin
          a0_reg   <= A_in;
          b0_reg   <= B_in;
          bin0_reg <= Bin_in;
        end
      end
      if (adv1) begin
        v1_reg <= v0_reg;
        if (v0_reg) begin
          d_lo1_reg <= d_lo_next;
          c1_reg    <= c_mid_next;
          a_hi1_reg <= a0_reg[WIDTH-1:HALF];
          b_hi1_reg <= b0_reg[WIDTH-1:HALF];
        end
      end
      if (adv2) begin
        out_valid <= v1_reg;
        if (v1_reg) begin
          D_out    <= {d_hi_next, d_lo1_reg};
          Bout_out <= ~c_top_next;
`ifdef BORROWSKIP_OVF_EN
          ovf_out  <= ovf_next;
`endif
        end
      end
    end
  end
endmodule

// File: tb/tb_borrowskip_sub_pipe.sv
module tb_borrowskip_sub_pipe;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [15:0] a_in, b_in, d_out;
  logic        bin_in, bout_out, ovf_obs;

  int          n_vec = 0;
  int          n_err = 0;
  int          n_pop = 0;
  logic [17:0] sb[$];

  always #5 clk = ~clk;

`ifdef BORROWSKIP_OVF_EN
  logic ovf_out;
  assign ovf_obs = ovf_out;
`else
  assign ovf_obs = 1'b0;
`endif

  borrowskip_sub_pipe dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A_in      (a_in),
    .B_in      (b_in),
    .Bin_in    (bin_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .D_out     (d_out),
`ifdef BORROWSKIP_OVF_EN
    .ovf_out   (ovf_out),
`endif
    .Bout_out  (bout_out)
  );

  // Reference: {ovf, bout, d} from plain integer arithmetic.
  function automatic logic [17:0] model(logic [15:0] a, logic [15:0] b, logic bin);
    logic [16:0] d;
    int          sa, sbv, r;
    logic        ovf;
    d   = {1'b0, a} - {1'b0, b} - {16'd0, bin};
    sa  = $signed(a);
    sbv = $signed(b);
    r   = sa - sbv - int'(bin);
    ovf = (r > 32767) || (r < -32768);
`ifndef BORROWSKIP_OVF_EN
    ovf = 1'b0;
`endif
    return {ovf, d[16], d[15:0]};
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(logic [15:0] a, logic [15:0] b, logic bin, logic v);
    a_in = a; b_in = b; bin_in = bin; in_valid = v;
  endtask

  // Evaluate the handshake just before the edge, clock once, settle.
  task automatic cycle(output bit in_fire);
    logic [17:0] e;
    #1;
    in_fire = in_valid && in_ready;
    if (out_valid && out_ready) begin
      chk("result_expected", 32'(sb.size() != 0), 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("result", {14'd0, ovf_obs, bout_out, d_out}, {14'd0, e});
        $display("pop  D=%h Bout=%b ovf=%b", d_out, bout_out, ovf_obs);
      end
      n_pop++;
    end
    if (in_fire) begin
      sb.push_back(model(a_in, b_in, bin_in));
      $display("push A=%h B=%h Bin=%b", a_in, b_in, bin_in);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    bit f;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) if (sb.size() != 0) cycle(f);
    chk("drain_done", sb.size(), 0);
  endtask

  initial begin
    bit          f;
    int          idx;
    logic [15:0] ta[5], tbv[5];

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a_in = '0; b_in = '0; bin_in = 1'b0;
    #2;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_d_out", d_out, 0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    // Latency: accept on edge k, valid after edge k+2.
    drive(16'h1234, 16'h0234, 1'b0, 1'b1);
    cycle(f);
    chk("lat_accept", f, 1);
    in_valid = 1'b0;
    chk("lat_k", out_valid, 0);
    cycle(f);
    chk("lat_k1", out_valid, 0);
    cycle(f);
    chk("lat_k2", out_valid, 1);
    chk("lat_d", d_out, 16'h1000);
    drain();

    // Directed corner vectors back-to-back.
    drive(16'h0000, 16'h0001, 1'b0, 1'b1); cycle(f);
    drive(16'h5555, 16'h5555, 1'b1, 1'b1); cycle(f);
    drive(16'h8000, 16'h0001, 1'b0, 1'b1); cycle(f);
    drive(16'h7FFF, 16'hFFFF, 1'b0, 1'b1); cycle(f);
    drive(16'hFFFF, 16'hFFFF, 1'b1, 1'b1); cycle(f);
    drive(16'h00FF, 16'h00FF, 1'b1, 1'b1); cycle(f);
    drain();

    // Random operands with random consumer backpressure.
    for (int i = 0; i < 30; i++) begin
      drive(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom_range(0, 3) != 0));
      out_ready = 1'($urandom_range(0, 2) != 0);
      cycle(f);
    end
    drain();

    // Stall: 5 offered, out_ready low for 6 cycles.
    for (int i = 0; i < 5; i++) begin
      ta[i] = 16'($urandom); tbv[i] = 16'($urandom);
    end
    out_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 6; c++) begin
      if (idx < 5) drive(ta[idx], tbv[idx], 1'b0, 1'b1);
      else in_valid = 1'b0;
      cycle(f);
      if (f) idx++;
      if (out_valid) chk("stall_hold", d_out, 32'(sb[0][15:0]));
    end
    chk("stall_accepted", idx, 3);
    #1;
    chk("stall_in_ready", in_ready, 0);
    out_ready = 1'b1;
    n_pop = 0;
    for (int c = 0; c < 5; c++) begin
      if (idx < 5) drive(ta[idx], tbv[idx], 1'b0, 1'b1);
      else in_valid = 1'b0;
      cycle(f);
      if (f) idx++;
    end
    chk("stall_pops", n_pop, 5);
    chk("stall_empty", out_valid, 0);

    // Asynchronous reset with the pipe full.
    out_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      drive(16'($urandom), 16'($urandom), 1'b0, 1'b1);
      cycle(f);
    end
    chk("full_in_ready", in_ready, 0);
    rst = 1'b1;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_d_out", d_out, 0);
    chk("arst_bout", bout_out, 0);
    chk("arst_in_ready", in_ready, 1);
    sb.delete();
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      cycle(f);
      chk("post_rst_idle", out_valid, 0);
    end
    drive(16'h8000, 16'h0001, 1'b0, 1'b1); cycle(f);
    chk("post_rst_accept", f, 1);
    drain();

    // Full pipe, simultaneous pop and push for 8 cycles.
    out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      drive(16'($urandom), 16'($urandom), 1'($urandom), 1'b1);
      cycle(f);
    end
    out_ready = 1'b1;
    n_pop = 0;
    for (int c = 0; c < 8; c++) begin
      drive(16'($urandom), 16'($urandom), 1'($urandom), 1'b1);
      #1;
      chk("pp_in_ready", in_ready, 1);
      chk("pp_out_valid", out_valid, 1);
      cycle(f);
    end
    chk("pp_pops", n_pop, 8);
    drain();
    chk("final_idle", out_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/borrowskip_sub_pipe.md
Name: borrowskip_sub_pipe

Overview:
- Pipelined 16-bit subtractor computing D = A - B - Bin; the inverse operation of the team's registered carry-bypass adder.
- Built from 4-bit skip blocks: a block's borrow-in is forwarded directly to its borrow-out when every bit of that block propagates.
- Low and high halves are split across pipeline stages. Valid/ready handshake on both sides, so it drops into the datapath between a producer and a consumer that applies backpressure.

Parameters:
- WIDTH, 16, operand width. Must be a multiple of 2*BLOCK.
- BLOCK, 4, skip-block width in bits.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  operand set present
- in_ready  out  1  block can accept an operand set this cycle
- A_in  in  WIDTH  minuend
- B_in  in  WIDTH  subtrahend
- Bin_in  in  1  borrow-in
- out_valid  out  1  result present
- out_ready  in  1  consumer accepts the result
- D_out  out  WIDTH  difference
- Bout_out  out  1  borrow-out (1 = A < B + Bin, unsigned)

Behaviour:
- Arithmetic:
  - D = A + ~B + ~Bin, computed through ripple full adders inside each BLOCK-bit block.
  - Block propagate = AND over the block of (A[i] ^ ~B[i]). When propagate = 1, the block's carry-out is taken from its carry-in through a 2:1 mux; otherwise it is the ripple carry-out.
  - Bout = ~carry-out of the top block.
  - All results are exact modulo 2^WIDTH; no saturation.
- Stage S0 (input register): captures A_in, B_in, Bin_in when in_valid && in_ready. Sets v0.
- Stage S1:
  - Computes the low WIDTH/2 bits of D and the mid carry from S0 contents.
  - Registers the low difference, the mid carry, and the untouched high halves of A and B. Sets v1.
- Stage S2 (output register): computes the high WIDTH/2 bits from S1 contents and registers D_out, Bout_out and out_valid.
- Stall rule, evaluated per stage:
  - adv2 = !out_valid || out_ready
  - adv1 = !v1 || (adv2 && v1)
  - adv0 = !v0 || adv1
  - in_ready = adv0 (combinational, no combinational path from in_valid)
  - A stage whose valid is low captures a bubble and clears its valid; payload registers hold their value.
- Latency: an operand set accepted on edge k appears with out_valid = 1 after edge k+2, i.e. 3 edges including the accept edge, when unstalled.
- Throughput: 1 result per cycle. Capacity: 3 entries, one per stage. Order is strictly preserved.
- Output hold: while out_valid && !out_ready, D_out and Bout_out remain stable. Upstream stages keep filling until full. When full, in_ready = 0.
- Simultaneous pop and push with the pipe full: the output pops, all stages shift, and a new operand set is accepted the same edge.
- Reset:
  - Asynchronous. Clears v0, v1 and out_valid immediately, with no wait for a clock edge.
  - Clears all payload registers, D_out and Bout_out to 0.
  - in_ready reads 1 while rst is high and after release.
  - In-flight operations are discarded; no stale result is ever presented after release.
- Idle: with no in_valid, the pipe drains and out_valid falls after the last result is consumed.

Optional Feature:
- Macro: BORROWSKIP_OVF_EN.
- When defined:
  - Adds output port ovf_out (1 bit, out), the signed two's-complement overflow of A - B - Bin = carry into MSB XOR carry out of MSB.
  - ovf_out is pipelined alongside D_out, reset to 0, and held under stall like D_out.
- When undefined: port and logic are absent; all other behaviour is identical.

Test Plan:
- A=0x1234, B=0x0234, Bin=0, accepted edge k, out_ready=1 -> out_valid after edge k+2. D=0x1000, Bout=0, ovf=0.
- A=0x0000, B=0x0001, Bin=0 -> D=0xFFFF, Bout=1. Borrow crosses every block and the S1/S2 boundary.
- A=0x5555, B=0x5555, Bin=1 -> D=0xFFFF, Bout=1, all four blocks on the bypass path. A=0x8000, B=0x0001, Bin=0 -> D=0x7FFF, Bout=0, ovf=1.
- Stream 5 operand sets back-to-back with out_ready=0 for 6 cycles -> exactly 3 accepted, in_ready=0 thereafter, D_out stable. Then out_ready=1 -> all 5 results emerge in order, one per cycle.
- Pipe holding 3 entries, rst asserted between edges -> out_valid=0 and D_out=0 before the next edge. After release, no output until new input is accepted; first new result is correct.
- Full pipe, out_ready=1 and in_valid=1 every cycle for 8 cycles -> 8 consecutive results, no bubbles, in_ready constantly 1.
